uart_rx_oversampled: RTL and testbench
======================================

// Module: uart_rx_oversampled
// PURPOSE
//   UART receiver: 8N1-style serial to parallel, LSB first, one start bit, one stop bit, no parity.
//   Paced by the oversample strobe Tick from the baud-rate generator (Tick = one Clk pulse per 1/OVERSAMPLE bit).
//   Generator setting: BaudRate = Fclk/(baud*OVERSAMPLE), e.g. 50 MHz, 115200 baud, x16 -> 27.
//   Output is a one-cycle RxValid strobe with RxData held stable; line errors are flagged, never stall.
// PARAMETERS
//   DATA_BITS   8   data bits per frame (5..9)
//   OVERSAMPLE  16  Tick pulses per bit period (even, >=4)
// PORTS
//   Clk       in   1          system clock, all logic on rising edge
//   Rst_n     in   1          asynchronous active-low reset
//   Tick      in   1          oversample strobe, one Clk wide
//   Rx        in   1          serial line, idle high, asynchronous to Clk
//   RxData    out  DATA_BITS  last received word; holds until next frame completes
//   RxValid   out  1          one-Clk pulse: RxData holds a good frame
//   FrameErr  out  1          one-Clk pulse: stop bit sampled low
//   Busy      out  1          high in any state except IDLE
// BEHAVIOUR
//   - Reset (async, Rst_n=0): state=IDLE, RxData=0, RxValid=0, FrameErr=0, Busy=0.
//     Sync flops=1, counters=0. Reset mid-frame aborts the frame, with no output pulse.
//   - Rx passes through a 2-flop synchronizer (reset value 1); rxs is the synchronized bit.
//     All decisions use rxs only.
//   - State advances only on Clk edges with Tick=1. Tick=0 freezes state and all counters.
//   - Counters: s_cnt (log2 OVERSAMPLE bits), n_cnt (bit index), shift register (DATA_BITS).
//   - IDLE: Tick && rxs==0 -> START, s_cnt=0.
//   - START: Tick && s_cnt==OVERSAMPLE/2-1 (mid start bit):
//       rxs==0 -> DATA, s_cnt=0, n_cnt=0.
//       rxs==1 -> IDLE (glitch rejected, no pulse).
//     Otherwise, on Tick: s_cnt++.
//   - DATA: Tick && s_cnt==OVERSAMPLE-1 -> shift={rxs,shift[DATA_BITS-1:1]}, s_cnt=0.
//       If n_cnt==DATA_BITS-1 -> STOP, else n_cnt++.
//     Otherwise, on Tick: s_cnt++.
//   - STOP: Tick && s_cnt==OVERSAMPLE-1 -> RxData<=shift, s_cnt=0.
//       rxs==1 -> RxValid=1 next cycle, -> IDLE.
//       rxs==0 -> FrameErr=1 next cycle, -> BREAK.
//     Otherwise, on Tick: s_cnt++.
//   - BREAK: wait for Tick && rxs==1 -> IDLE. A held-low line yields exactly one FrameErr.
//   - RxValid and FrameErr are registered and mutually exclusive.
//     Each deasserts the following Clk regardless of Tick.
//   - Next start bit is accepted on the first Tick after returning to IDLE.
//     Back-to-back frames with a single stop bit need no idle gap.
//   - Latency: RxValid asserts in the Clk after the Tick that samples mid-stop.
//     That Tick falls (DATA_BITS+1.5)*OVERSAMPLE Ticks after the start edge is seen in IDLE.
//     Add 2 Clk for the synchronizer.
//   - Tick asserted every Clk (BaudRate=1 at generator) is legal. No other constraint on Tick spacing.
// TESTING (Clk 10 ns, Tick every 4 Clk, OVERSAMPLE=16 -> bit = 64 Clk)
//   1. Send 0xA5 with stop=1 -> one RxValid pulse, RxData=0xA5, FrameErr never high.
//      Busy low again within 1 bit.
//   2. Rx low for 3 Ticks then high -> no RxValid/FrameErr, state back to IDLE.
//      A following 0x3C frame is received correctly.
//   3. Send 0x81 with stop=0, then hold Rx low for 20 bit times -> exactly one FrameErr, no RxValid.
//      RxData=0x81. After Rx goes high, 0x55 is received with RxValid.
//   4. Back-to-back 0x00, 0xFF, 0x7E with no idle gap -> three RxValid pulses, data in order.
//   5. Pull Rst_n low mid-DATA of 0x12 -> all outputs 0 immediately.
//      After release, the next 0x34 is received and no pulse is produced for 0x12.
//   6. Hold Tick=0 for 500 Clk mid-frame, then resume -> frame completes with correct data.
//      Counters do not advance during the gap.

Source files
------------

// File: rtl/uart_rx_oversampled.sv
// UART receiver, 8N1-style, LSB first, paced by an oversample tick strobe.
`timescale 1ns/1ps
module uart_rx_oversampled #(
   parameter int unsigned DATA_BITS  = 8,
   parameter int unsigned OVERSAMPLE = 16
) (
   input  logic                 Clk,
   input  logic                 Rst_n,
   input  logic                 Tick,
   input  logic                 Rx,
   output logic [DATA_BITS-1:0] RxData,
   output logic                 RxValid,
   output logic                 FrameErr,
   output logic                 Busy
);

   localparam int unsigned SW = $clog2(OVERSAMPLE);
   localparam int unsigned NW = $clog2(DATA_BITS);
   localparam logic [SW-1:0] S_MID  = SW'(OVERSAMPLE / 2 - 1);
   localparam logic [SW-1:0] S_END  = SW'(OVERSAMPLE - 1);
   localparam logic [NW-1:0] N_LAST = NW'(DATA_BITS - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_START = 3'd1,
      ST_DATA  = 3'd2,
      ST_STOP  = 3'd3,
      ST_BREAK = 3'd4
   } state_e;

   state_e                 state_q, state_d;
   logic [1:0]             sync_q;
   logic [SW-1:0]          s_cnt_q, s_cnt_d;
   logic [NW-1:0]          n_cnt_q, n_cnt_d;
   logic [DATA_BITS-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0]   rx_data_q, rx_data_d;
   logic                   rx_valid_q, rx_valid_d;
   logic                   frame_err_q, frame_err_d;
   logic                   rxs;

   assign rxs      = sync_q[1];
   assign RxData   = rx_data_q;
   assign RxValid  = rx_valid_q;
   assign FrameErr = frame_err_q;
   assign Busy     = (state_q != ST_IDLE);

   // Two-flop synchronizer for the asynchronous serial line; resets to idle-high.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         sync_q <= 2'b11;
      end else begin
         sync_q <= {sync_q[0], Rx};
      end
   end

   // State, counters, shift register and output pulse registers.
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         state_q     <= ST_IDLE;
         s_cnt_q     <= '0;
         n_cnt_q     <= '0;
         shift_q     <= '0;
         rx_data_q   <= '0;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         s_cnt_q     <= s_cnt_d;
         n_cnt_q     <= n_cnt_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
      end
   end

   // Frame sequencing; everything holds when Tick is low, pulses self-clear.
   always_comb begin
      state_d     = state_q;
      s_cnt_d     = s_cnt_q;
      n_cnt_d     = n_cnt_q;
      shift_d     = shift_q;
      rx_data_d   = rx_data_q;
      rx_valid_d  = 1'b0;
      frame_err_d = 1'b0;
      if (Tick) begin
         unique case (state_q)
            ST_IDLE: begin
               if (!rxs) begin
                  state_d = ST_START;
                  s_cnt_d = '0;
               end
            end
            ST_START: begin
               if (s_cnt_q == S_MID) begin
                  if (!rxs) begin
                     state_d = ST_DATA;
                     s_cnt_d = '0;
                     n_cnt_d = '0;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
            ST_DATA: begin
               if (s_cnt_q == S_END) begin
                  shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                  s_cnt_d = '0;
                  if (n_cnt_q == N_LAST) begin
                     state_d = ST_STOP;
                  end else begin
                     n_cnt_d = n_cnt_q + NW'(1);
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
            ST_STOP: begin
               if (s_cnt_q == S_END) begin
                  rx_data_d = shift_q;
                  s_cnt_d   = '0;
                  if (rxs) begin
                     rx_valid_d = 1'b1;
                     state_d    = ST_IDLE;
                  end else begin
                     frame_err_d = 1'b1;
                     state_d     = ST_BREAK;
                  end
               end else begin
                  s_cnt_d = s_cnt_q + SW'(1);
               end
            end
            ST_BREAK: begin
               if (rxs) begin
                  state_d = ST_IDLE;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_oversampled.sv
// Directed bench for uart_rx_oversampled: Clk 10 ns, Tick every 4 Clk, 64 Clk per bit.
`timescale 1ns/1ps
module tb_uart_rx_oversampled;

   localparam int BIT = 64;

   logic       Clk;
   logic       Rst_n;
   logic       Tick;
   logic       Rx;
   logic [7:0] RxData;
   logic       RxValid;
   logic       FrameErr;
   logic       Busy;

   logic       tick_en;
   int         tick_div;
   int         n_vec;
   int         n_err;
   int         valid_cnt;
   int         ferr_cnt;
   int         both_cnt;
   logic [7:0] rxq[$];

   uart_rx_oversampled #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
      .Clk     (Clk),
      .Rst_n   (Rst_n),
      .Tick    (Tick),
      .Rx      (Rx),
      .RxData  (RxData),
      .RxValid (RxValid),
      .FrameErr(FrameErr),
      .Busy    (Busy)
   );

   initial begin
      Clk = 1'b0;
      forever #5 Clk = ~Clk;
   end

   // Tick strobe: one Clk high every 4 Clk while enabled, driven on the falling edge.
   initial begin
      Tick     = 1'b0;
      tick_div = 0;
      forever begin
         @(negedge Clk);
         tick_div = (tick_div + 1) % 4;
         Tick     = tick_en && (tick_div == 0);
      end
   end

   // Output monitor: counts pulses and records received words in order.
   always @(negedge Clk) begin
      if (RxValid) begin
         valid_cnt++;
         rxq.push_back(RxData);
      end
      if (FrameErr) ferr_cnt++;
      if (RxValid && FrameErr) both_cnt++;
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic wait_clk(input int n);
      repeat (n) @(negedge Clk);
   endtask

   function automatic logic [31:0] pop_word();
      if (rxq.size() == 0) return 32'hFFFF_FFFF;
      return 32'(rxq.pop_front());
   endfunction

   task automatic send_frame(input logic [7:0] d, input logic stop);
      Rx = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 8; i++) begin
         Rx = d[i];
         wait_clk(BIT);
      end
      Rx = stop;
      wait_clk(BIT);
   endtask

   initial begin
      int v0;
      int f0;
      n_vec = 0; n_err = 0; valid_cnt = 0; ferr_cnt = 0; both_cnt = 0;
      tick_en = 1'b1;
      Rst_n   = 1'b0;
      Rx      = 1'b1;
      wait_clk(3);
      check_eq("reset_rxdata",   32'(RxData),   32'h0);
      check_eq("reset_rxvalid",  32'(RxValid),  32'h0);
      check_eq("reset_frameerr", 32'(FrameErr), 32'h0);
      check_eq("reset_busy",     32'(Busy),     32'h0);
      Rst_n = 1'b1;
      wait_clk(BIT);

      // 1: plain frame 0xA5
      v0 = valid_cnt; f0 = ferr_cnt; rxq.delete();
      send_frame(8'hA5, 1'b1);
      check_eq("t1_busy_end_of_stop", 32'(Busy), 32'h0);
      wait_clk(BIT);
      check_eq("t1_valid_count", 32'(valid_cnt - v0), 32'd1);
      check_eq("t1_data",        pop_word(),           32'hA5);
      check_eq("t1_ferr_count",  32'(ferr_cnt - f0),  32'd0);

      // 2: short start glitch is rejected, then 0x3C
      v0 = valid_cnt; f0 = ferr_cnt; rxq.delete();
      Rx = 1'b0;
      wait_clk(12);
      Rx = 1'b1;
      wait_clk(BIT);
      check_eq("t2_busy_after_glitch",  32'(Busy),            32'h0);
      check_eq("t2_valid_after_glitch", 32'(valid_cnt - v0), 32'd0);
      check_eq("t2_ferr_after_glitch",  32'(ferr_cnt - f0),  32'd0);
      send_frame(8'h3C, 1'b1);
      wait_clk(BIT);
      check_eq("t2_valid_count", 32'(valid_cnt - v0), 32'd1);
      check_eq("t2_data",        pop_word(),           32'h3C);

      // 3: bad stop bit, long break, then 0x55
      v0 = valid_cnt; f0 = ferr_cnt; rxq.delete();
      send_frame(8'h81, 1'b0);
      wait_clk(20 * BIT);
      check_eq("t3_busy_in_break",  32'(Busy),            32'h1);
      Rx = 1'b1;
      wait_clk(BIT);
      check_eq("t3_ferr_count",  32'(ferr_cnt - f0),  32'd1);
      check_eq("t3_valid_count", 32'(valid_cnt - v0), 32'd0);
      check_eq("t3_rxdata",      32'(RxData),         32'h81);
      check_eq("t3_busy_idle",   32'(Busy),           32'h0);
      send_frame(8'h55, 1'b1);
      wait_clk(BIT);
      check_eq("t3_valid_after", 32'(valid_cnt - v0), 32'd1);
      check_eq("t3_data_after",  pop_word(),           32'h55);

      // 4: back-to-back frames with no idle gap
      v0 = valid_cnt; f0 = ferr_cnt; rxq.delete();
      send_frame(8'h00, 1'b1);
      send_frame(8'hFF, 1'b1);
      send_frame(8'h7E, 1'b1);
      wait_clk(BIT);
      check_eq("t4_valid_count", 32'(valid_cnt - v0), 32'd3);
      check_eq("t4_data0",       pop_word(),           32'h00);
      check_eq("t4_data1",       pop_word(),           32'hFF);
      check_eq("t4_data2",       pop_word(),           32'h7E);
      check_eq("t4_ferr_count",  32'(ferr_cnt - f0),  32'd0);

      // 5: reset mid-DATA of 0x12, then 0x34
      v0 = valid_cnt; f0 = ferr_cnt; rxq.delete();
      Rx = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 3; i++) begin
         Rx = (8'h12 >> i) & 8'h01;
         wait_clk(BIT);
      end
      Rx = 1'b0;
      wait_clk(20);
      check_eq("t5_busy_before_reset", 32'(Busy), 32'h1);
      Rst_n = 1'b0;
      #1;
      check_eq("t5_rst_rxdata",   32'(RxData),   32'h0);
      check_eq("t5_rst_rxvalid",  32'(RxValid),  32'h0);
      check_eq("t5_rst_frameerr", 32'(FrameErr), 32'h0);
      check_eq("t5_rst_busy",     32'(Busy),     32'h0);
      Rx = 1'b1;
      wait_clk(5);
      Rst_n = 1'b1;
      wait_clk(BIT);
      send_frame(8'h34, 1'b1);
      wait_clk(BIT);
      check_eq("t5_valid_count", 32'(valid_cnt - v0), 32'd1);
      check_eq("t5_data",        pop_word(),           32'h34);
      check_eq("t5_ferr_count",  32'(ferr_cnt - f0),  32'd0);

      // 6: Tick frozen for 500 Clk in the middle of 0xC3
      v0 = valid_cnt; f0 = ferr_cnt; rxq.delete();
      Rx = 1'b0;
      wait_clk(BIT);
      for (int i = 0; i < 8; i++) begin
         Rx = (8'hC3 >> i) & 8'h01;
         if (i == 4) begin
            wait_clk(BIT / 2);
            tick_en = 1'b0;
            wait_clk(500);
            check_eq("t6_busy_in_gap",  32'(Busy),            32'h1);
            check_eq("t6_valid_in_gap", 32'(valid_cnt - v0), 32'd0);
            tick_en = 1'b1;
            wait_clk(BIT / 2);
         end else begin
            wait_clk(BIT);
         end
      end
      Rx = 1'b1;
      wait_clk(2 * BIT);
      check_eq("t6_valid_count", 32'(valid_cnt - v0), 32'd1);
      check_eq("t6_data",        pop_word(),           32'hC3);
      check_eq("t6_ferr_count",  32'(ferr_cnt - f0),  32'd0);

      check_eq("valid_ferr_exclusive", 32'(both_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
